// File: rtl/car_cmd_parser.sv
// Parses SYNC/CMD/SPD/CHK frames from the UART receiver into registered drive, steer and speed outputs.
// Define CAR_CMD_WATCHDOG_EN to enable the link watchdog that stops the car when good frames stop arriving.
module car_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned GAP_CYCLES  = 50000,
  parameter int unsigned WDOG_CYCLES = 25000000
) (
  input  logic       clk_50m,
  input  logic       clear_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_ready_clr,
  output logic [1:0] drive,
  output logic [1:0] steer,
  output logic [7:0] speed,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       link_ok,
  output logic [7:0] err_count
);

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_GET_CMD   = 2'd1;
  localparam logic [1:0] ST_GET_SPD   = 2'd2;
  localparam logic [1:0] ST_GET_CHK   = 2'd3;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  function automatic logic frame_good(input logic [7:0] cmd, input logic [7:0] spd,
                                      input logic [7:0] chk);
    return (chk == (cmd ^ spd)) && (cmd[7:4] == 4'h0) && (cmd[3:2] != 2'b11);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       spd_q, spd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             clr_q, clr_d;
  logic [1:0]       drive_q, drive_d;
  logic [1:0]       steer_q, steer_d;
  logic [7:0]       speed_q, speed_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             link_q, link_d;
  logic [7:0]       errc_q, errc_d;
  logic             accept_s;
  logic             good_s;
  logic             err_s;
  logic             wdog_exp_s;

  // Frame assembly FSM and inter-byte gap timer; a byte accept always beats gap expiry.
  always_comb begin
    accept_s = rx_ready && !clr_q;
    clr_d    = accept_s;
    state_d  = state_q;
    cmd_d    = cmd_q;
    spd_d    = spd_q;
    good_s   = 1'b0;
    err_s    = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_WAIT_SYNC: state_d = (rx_data == SYNC_BYTE) ? ST_GET_CMD : ST_WAIT_SYNC;
        ST_GET_CMD: begin
          cmd_d   = rx_data;
          state_d = ST_GET_SPD;
        end
        ST_GET_SPD: begin
          spd_d   = rx_data;
          state_d = ST_GET_CHK;
        end
        ST_GET_CHK: begin
          state_d = ST_WAIT_SYNC;
          if (frame_good(cmd_q, spd_q, rx_data)) begin
            good_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end
        default: state_d = ST_WAIT_SYNC;
      endcase
    end else if ((state_q != ST_WAIT_SYNC) && (gap_q == GAP_LAST)) begin
      state_d = ST_WAIT_SYNC;
      err_s   = 1'b1;
    end else begin
      state_d = state_q;
    end
    if (accept_s || (state_d == ST_WAIT_SYNC)) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

`ifdef CAR_CMD_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_END  = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Link watchdog: restarts on a good frame, otherwise counts up and parks once expired.
  always_comb begin
    wdog_exp_s = (wdog_q == WDOG_LAST) && !good_s;
    if (good_s) begin
      wdog_d = '0;
    end else if (wdog_q != WDOG_END) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_50m or negedge clear_n) begin
    if (!clear_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_exp_s = 1'b0;
`endif

  // Output update: a good frame beats a simultaneous watchdog expiry.
  always_comb begin
    valid_d = good_s;
    ferr_d  = err_s;
    if (good_s) begin
      drive_d = cmd_q[1:0];
      steer_d = cmd_q[3:2];
      speed_d = spd_q;
      link_d  = 1'b1;
    end else if (wdog_exp_s) begin
      drive_d = 2'b00;
      steer_d = steer_q;
      speed_d = 8'h00;
      link_d  = 1'b0;
    end else begin
      drive_d = drive_q;
      steer_d = steer_q;
      speed_d = speed_q;
      link_d  = link_q;
    end
    if (err_s && (errc_q != 8'hFF)) begin
      errc_d = errc_q + 8'd1;
    end else begin
      errc_d = errc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_50m or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_WAIT_SYNC;
      cmd_q   <= 8'h00;
      spd_q   <= 8'h00;
      gap_q   <= '0;
      clr_q   <= 1'b0;
      drive_q <= 2'b00;
      steer_q <= 2'b00;
      speed_q <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      link_q  <= 1'b0;
      errc_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      spd_q   <= spd_d;
      gap_q   <= gap_d;
      clr_q   <= clr_d;
      drive_q <= drive_d;
      steer_q <= steer_d;
      speed_q <= speed_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      link_q  <= link_d;
      errc_q  <= errc_d;
    end
  end

  assign rx_ready_clr = clr_q;
  assign drive        = drive_q;
  assign steer        = steer_q;
  assign speed        = speed_q;
  assign cmd_valid    = valid_q;
  assign frame_err    = ferr_q;
  assign link_ok      = link_q;
  assign err_count    = errc_q;

endmodule
